// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit: radix-2 restoring division, one quotient bit per cycle,
// with RISC-V divide-by-zero and signed-overflow results produced on a one-cycle fast path.
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_op,
   input  logic [DATA_WIDTH-1:0] req_a,
   input  logic [DATA_WIDTH-1:0] req_b,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_result,
   output logic                  resp_div_by_zero
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(W) + 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t           r_state;
   state_t           w_nextState;
   logic             r_isRem;
   logic             r_negQ;
   logic             r_negR;
   logic             r_dbz;
   logic [W-1:0]     r_rem;
   logic [W-1:0]     r_quo;
   logic [W-1:0]     r_div;
   logic [W-1:0]     r_result;
   logic [CNT_W-1:0] r_cnt;

   logic             w_accept;
   logic             w_signedOp;
   logic             w_aNeg;
   logic             w_bNeg;
   logic             w_bZero;
   logic             w_ovf;
   logic [W-1:0]     w_absA;
   logic [W-1:0]     w_absB;
   logic [W:0]       w_remSh;
   logic [W:0]       w_trial;
   logic             w_trialOk;
   logic [W-1:0]     w_remNext;
   logic [W-1:0]     w_quoNext;
   logic [W-1:0]     w_quoFinal;
   logic [W-1:0]     w_remFinal;
   logic             w_last;

   assign req_ready        = (r_state == IDLE) && !rst;
   assign resp_valid       = (r_state == DONE);
   assign resp_result      = r_result;
   assign resp_div_by_zero = r_dbz;

   // Ops 0 and 2 (DIV, REM) are signed; ops 2 and 3 (REM, REMU) return the remainder.
   assign w_accept   = req_valid && req_ready;
   assign w_signedOp = !req_op[0];
   assign w_aNeg     = w_signedOp && req_a[W-1];
   assign w_bNeg     = w_signedOp && req_b[W-1];
   assign w_absA     = w_aNeg ? ({W{1'b0}} - req_a) : req_a;
   assign w_absB     = w_bNeg ? ({W{1'b0}} - req_b) : req_b;
   assign w_bZero    = (req_b == {W{1'b0}});
   assign w_ovf      = w_signedOp && (req_a == {1'b1, {(W-1){1'b0}}}) && (req_b == {W{1'b1}});

   // The partial remainder is always below the divisor, so the W+1 bit trial difference
   // cannot wrap and its top bit is a true sign.
   assign w_remSh    = {r_rem, r_quo[W-1]};
   assign w_trial    = w_remSh - {1'b0, r_div};
   assign w_trialOk  = !w_trial[W];
   assign w_remNext  = w_trialOk ? w_trial[W-1:0] : w_remSh[W-1:0];
   assign w_quoNext  = {r_quo[W-2:0], w_trialOk};
   assign w_quoFinal = r_negQ ? ({W{1'b0}} - w_quoNext) : w_quoNext;
   assign w_remFinal = r_negR ? ({W{1'b0}} - w_remNext) : w_remNext;
   assign w_last     = (r_cnt == LAST_ITER);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_nextState = (w_bZero || w_ovf) ? DONE : CALC;
            end
         end
         CALC: begin
            if (w_last) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (resp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Datapath: operand capture on accept, one restoring step per CALC cycle, result held in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_isRem  <= 1'b0;
         r_negQ   <= 1'b0;
         r_negR   <= 1'b0;
         r_dbz    <= 1'b0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_result <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_isRem <= req_op[1];
                  if (w_bZero) begin
                     r_result <= req_op[1] ? req_a : {W{1'b1}};
                     r_dbz    <= 1'b1;
                  end else if (w_ovf) begin
                     r_result <= req_op[1] ? {W{1'b0}} : req_a;
                     r_dbz    <= 1'b0;
                  end else begin
                     r_rem  <= '0;
                     r_quo  <= w_absA;
                     r_div  <= w_absB;
                     r_cnt  <= '0;
                     r_negQ <= w_aNeg ^ w_bNeg;
                     r_negR <= w_aNeg;
                     r_dbz  <= 1'b0;
                  end
               end
            end
            CALC: begin
               r_rem <= w_remNext;
               r_quo <= w_quoNext;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_result <= r_isRem ? w_remFinal : w_quoFinal;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, backpressure and mid-op reset
// sequences, then randomized ops against an arithmetic reference model.
module tb_div_unit;

   localparam int W = 32;
   localparam int NORMAL_LAT = W + 1;

   logic         clk;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] resp_result;
   logic         resp_div_by_zero;

   int passCount;
   int totalCount;

   div_unit #(.DATA_WIDTH(W)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_op           (req_op),
      .req_a            (req_a),
      .req_b            (req_b),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_result      (resp_result),
      .resp_div_by_zero (resp_div_by_zero)
   );

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] expRes;
      logic         expDbz;
      int           expLat;
   } vec_t;

   vec_t vecs[10];

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a wait is ever left unbounded
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      totalCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Reference: RISC-V M-extension semantics computed with plain arithmetic
   task automatic refModel(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] res, output logic dbz, output int lat);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      logic                isSigned;
      sa       = a;
      sb       = b;
      isSigned = (op == 2'd0) || (op == 2'd2);
      dbz      = 1'b0;
      lat      = NORMAL_LAT;
      if (b == 0) begin
         dbz = 1'b1;
         lat = 1;
         res = (op >= 2'd2) ? a : 32'hFFFF_FFFF;
      end else if (isSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lat = 1;
         res = (op == 2'd0) ? a : 32'h0;
      end else begin
         case (op)
            2'd0:    res = sa / sb;
            2'd1:    res = a / b;
            2'd2:    res = sa % sb;
            default: res = a % b;
         endcase
      end
   endtask

   // Issue one request, measure latency, optionally stall the response, then complete it
   task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input int holdCycles, input logic readyEarly,
                                output logic [W-1:0] res, output logic dbz, output int lat);
      int n;
      req_op     = op;
      req_a      = a;
      req_b      = b;
      req_valid  = 1'b1;
      resp_ready = 1'b0;
      n = 0;
      while (!req_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("acceptReady", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_op     = 2'($urandom);
      req_a      = $urandom;
      req_b      = $urandom;
      resp_ready = readyEarly;
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = resp_result;
      dbz = resp_div_by_zero;
      if (!readyEarly) begin
         for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk); #1;
            checkOutput("holdResult", resp_result, res);
         end
         resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   initial begin
      logic [W-1:0] res;
      logic [W-1:0] expRes;
      logic         dbz;
      logic         expDbz;
      int           lat;
      int           expLat;
      int           n;
      int           seen;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;

      passCount  = 0;
      totalCount = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'd0;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b0;

      vecs[0] = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0, NORMAL_LAT};
      vecs[1] = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0, NORMAL_LAT};
      vecs[2] = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, NORMAL_LAT};
      vecs[3] = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, NORMAL_LAT};
      vecs[4] = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, NORMAL_LAT};
      vecs[5] = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1};
      vecs[6] = '{2'd3, 32'd5,          32'd0,          32'd5,          1'b1, 1};
      vecs[7] = '{2'd0, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  1'b1, 1};
      vecs[8] = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1};
      vecs[9] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, 1};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rstReqReady",  {31'b0, req_ready}, 32'd0);
      checkOutput("rstRespValid", {31'b0, resp_valid}, 32'd0);
      checkOutput("rstResult",    resp_result, 32'd0);
      checkOutput("rstDbz",       {31'b0, resp_div_by_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("postRstReqReady", {31'b0, req_ready}, 32'd1);

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, i % 3, (i % 4) == 3, res, dbz, lat);
         checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expRes);
         checkOutput($sformatf("vec%0d_dbz", i), {31'b0, dbz}, {31'b0, vecs[i].expDbz});
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
      end

      // Backpressure with a second request waiting
      req_op    = 2'd1;
      req_a     = 32'd1000;
      req_b     = 32'd10;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_op = 2'd3;
      req_a  = 32'd1000;
      req_b  = 32'd7;
      n = 0;
      while (!resp_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("bpFirstResult", resp_result, 32'd100);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bpHoldResult",   resp_result, 32'd100);
         checkOutput("bpHoldValid",    {31'b0, resp_valid}, 32'd1);
         checkOutput("bpHoldReqReady", {31'b0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput("bpRespDropped", {31'b0, resp_valid}, 32'd0);
      checkOutput("bpReqReady",    {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("bpAccepted", {31'b0, req_ready}, 32'd0);
      lat = 1;
      while (!resp_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("bpSecondLatency", lat, NORMAL_LAT);
      checkOutput("bpSecondResult",  resp_result, 32'd6);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;

      // Reset during the 10th CALC cycle aborts the operation
      req_op    = 2'd0;
      req_a     = 32'h1234_5678;
      req_b     = 32'h0000_0077;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("midRstReqReady", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midRstRespValid", {31'b0, resp_valid}, 32'd0);
      @(posedge clk); #1;
      checkOutput("midRstIdle", {31'b0, req_ready}, 32'd1);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      checkOutput("midRstNoResponse", seen, 32'd0);
      applyStimulus(2'd1, 32'd9, 32'd3, 0, 1'b0, res, dbz, lat);
      checkOutput("postRstDivu", res, 32'd3);

      // Randomized ops against the reference model
      for (int i = 0; i < 1000; i++) begin
         op = 2'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 255);
            4: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         refModel(op, a, b, expRes, expDbz, expLat);
         applyStimulus(op, a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)), res, dbz, lat);
         checkOutput($sformatf("rand%0d_result", i), res, expRes);
         checkOutput($sformatf("rand%0d_dbz", i), {31'b0, dbz}, {31'b0, expDbz});
         checkOutput($sformatf("rand%0d_latency", i), lat, expLat);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
